// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences multi-cycle mult/div into HI/LO and stalls decode-stage HI/LO users.
// Define MULDIV_DIV_EN to build the DIV/DIVU path; without it ops 3/4 behave as no-ops.
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [4:0] MULT_LEN = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LEN  = 5'(DIV_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateE;

    // All control state lives in one struct so checkers can bind to a single signal.
    typedef struct packed {
        stateE      state;
        logic [4:0] cnt;
        logic       pValid;
    } ctrlT;

    // Valid/ready: a command is taken when start=1 on an edge while IDLE; in RUN it is
    // dropped, and stall is what keeps the pipeline from presenting one then.
    ctrlT        ctrl;
    ctrlT        ctrlNext;
    logic [31:0] pHi;
    logic [31:0] pLo;
    logic        isMul;
    logic        isDiv;
    logic        loadPend;
    logic        commit;
    logic        writeHi;
    logic        writeLo;
    logic [31:0] resHi;
    logic [31:0] resLo;
    logic        resValid;
    logic [63:0] prodS;
    logic [63:0] prodU;

    assign isMul = (op == OP_MULT) || (op == OP_MULTU);

    // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply the signed product.
    assign prodS = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prodU = {32'd0, a} * {32'd0, b};

`ifdef MULDIV_DIV_EN
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_DIVU = 3'd4;

    logic        divSigned;
    logic        negA;
    logic        negB;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [31:0] quoU;
    logic [31:0] remU;
    logic [31:0] quo;
    logic [31:0] rem;

    assign isDiv = (op == OP_DIV) || (op == OP_DIVU);

    // Magnitude divide then fix signs; 0x80000000/-1 falls out as 0x80000000 rem 0.
    always_comb begin
        divSigned = (op == OP_DIV);
        negA      = divSigned & a[31];
        negB      = divSigned & b[31];
        absA      = negA ? (~a + 32'd1) : a;
        absB      = negB ? (~b + 32'd1) : b;
        quoU      = (absB != 32'd0) ? (absA / absB) : 32'd0;
        remU      = (absB != 32'd0) ? (absA % absB) : 32'd0;
        quo       = (negA ^ negB) ? (~quoU + 32'd1) : quoU;
        rem       = negA ? (~remU + 32'd1) : remU;
    end
`else
    assign isDiv = 1'b0;
`endif

    always_comb begin
        resHi    = prodU[63:32];
        resLo    = prodU[31:0];
        resValid = 1'b1;
        if (op == OP_MULT) begin
            resHi = prodS[63:32];
            resLo = prodS[31:0];
        end
`ifdef MULDIV_DIV_EN
        else if (isDiv) begin
            resHi    = rem;
            resLo    = quo;
            resValid = (b != 32'd0);
        end
`endif
    end

    always_comb begin
        ctrlNext = ctrl;
        loadPend = 1'b0;
        commit   = 1'b0;
        writeHi  = 1'b0;
        writeLo  = 1'b0;
        case (ctrl.state)
            IDLE: begin
                if (start) begin
                    if (isMul || isDiv) begin
                        ctrlNext.state  = RUN;
                        ctrlNext.cnt    = isDiv ? DIV_LEN : MULT_LEN;
                        ctrlNext.pValid = resValid;
                        loadPend        = 1'b1;
                    end
                    writeHi = (op == OP_MTHI);
                    writeLo = (op == OP_MTLO);
                end
            end
            RUN: begin
                ctrlNext.cnt = ctrl.cnt - 5'd1;
                if (ctrl.cnt <= 5'd1) begin
                    ctrlNext.state = IDLE;
                    ctrlNext.cnt   = 5'd0;
                    commit         = ctrl.pValid;
                end
            end
            default: ctrlNext = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl <= '0;
        end else begin
            ctrl <= ctrlNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi  <= 32'd0;
            lo  <= 32'd0;
            pHi <= 32'd0;
            pLo <= 32'd0;
        end else begin
            if (loadPend) begin
                pHi <= resHi;
                pLo <= resLo;
            end
            if (commit) begin
                hi <= pHi;
                lo <= pLo;
            end else begin
                if (writeHi) hi <= a;
                if (writeLo) lo <= a;
            end
        end
    end

    assign busy  = (ctrl.state == RUN);
    assign stall = md_use_D & (busy | (start & (isMul | isDiv)));

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized and directed checks of muldiv_ctrl against an arithmetic HI/LO model.
// Honours MULDIV_DIV_EN the same way the design does.
module tb_muldiv_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  muldiv_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .md_use_D(md_use_D), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: architectural HI/LO, cycles the unit stays occupied, queued results
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          m_left;
  logic        m_pvalid;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_md_op(input logic [2:0] o);
    return (o == 3'd1) || (o == 3'd2) || (DIV_EN && ((o == 3'd3) || (o == 3'd4)));
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int ix, iy;
    longint sx, sy, q, r;
    logic [63:0] qv, rv;
    ix = x;
    iy = y;
    sx = ix;
    sy = iy;
    case (o)
      3'd1: return sx * sy;
      3'd2: return {32'd0, x} * {32'd0, y};
      3'd3: begin
        q = sx / sy;
        r = sx % sy;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
      end
      default: return {x % y, x / y};
    endcase
  endfunction

  task automatic model_reset();
    m_hi = 32'd0;
    m_lo = 32'd0;
    m_left = 0;
    m_pvalid = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pvalid) {m_hi, m_lo} = exp_q.pop_front();
    end else if (s) begin
      if (is_md_op(o)) begin
        m_left = (o >= 3'd3) ? DIV_N : MULT_N;
        m_pvalid = !((o >= 3'd3) && (y == 32'd0));
        if (m_pvalid) exp_q.push_back(ref_result(o, x, y));
      end else if (o == 3'd5) begin
        m_hi = x;
      end else if (o == 3'd6) begin
        m_lo = x;
      end
    end
  endtask

  // driver: called #1 after a rising edge; returns #1 after the next rising edge
  task automatic drive_cycle(input logic s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                             input logic md, output logic obs_s, output logic exp_s);
    start = s;
    op = o;
    a = x;
    b = y;
    md_use_D = md;
    #1;
    obs_s = stall;
    exp_s = md && ((m_left > 0) || (s && is_md_op(o)));
    @(posedge clk);
    model_edge(s, o, x, y);
    #1;
  endtask

  task automatic run_cmd(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic md,
                         input int cycles, input string tag, output int busy_seen, output int stall_seen);
    logic os, es;
    busy_seen = 0;
    stall_seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (i == 0) drive_cycle(1'b1, o, x, y, md, os, es);
      else drive_cycle(1'b0, 3'd0, 32'd0, 32'd0, md, os, es);
      if (busy) busy_seen++;
      if (os) stall_seen++;
      n_checks++;
      if ({os, busy, hi, lo} !== {es, (m_left > 0), m_hi, m_lo}) begin
        n_fail++;
        $display("FAIL %s cyc%0d: stall/busy/hi/lo got %b %b %h %h want %b %b %h %h",
                 tag, i, os, busy, hi, lo, es, (m_left > 0), m_hi, m_lo);
      end
    end
  endtask

  task automatic test_reset();
    md_use_D = 1'b1;
    #1;
    n_checks++;
    if ({hi, lo, busy, stall} !== {64'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: hi/lo/busy/stall got %h %h %b %b want 0 0 0 0", hi, lo, busy, stall);
    end
    md_use_D = 1'b0;
  endtask

  task automatic test_mult();
    int bs, ss;
    run_cmd(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, MULT_N + 1, "mult", bs, ss);
    n_checks++;
    if ({hi, lo, 32'(bs)} !== {32'hFFFFFFFF, 32'hFFFFFFFA, 32'(MULT_N)}) begin
      n_fail++;
      $display("FAIL mult_result: hi/lo/busy_cycles got %h %h %0d want ffffffff fffffffa %0d", hi, lo, bs, MULT_N);
    end
    run_cmd(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0, MULT_N + 1, "multu", bs, ss);
    n_checks++;
    if ({hi, lo} !== {32'h00000002, 32'hFFFFFFFA}) begin
      n_fail++;
      $display("FAIL multu_result: hi/lo got %h %h want 00000002 fffffffa", hi, lo);
    end
  endtask

  task automatic test_stall();
    int bs, ss;
    logic os, es;
    // start cycle plus every busy cycle
    run_cmd(3'd1, 32'd1000, 32'd1000, 1'b1, MULT_N + 1, "stall", bs, ss);
    n_checks++;
    if (ss !== MULT_N + 1) begin
      n_fail++;
      $display("FAIL stall_cycles: got %0d want %0d", ss, MULT_N + 1);
    end
    drive_cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, os, es);
    n_checks++;
    if ({os, hi, lo} !== {1'b0, 32'd0, 32'd1000000}) begin
      n_fail++;
      $display("FAIL stall_commit_cycle: stall/hi/lo got %b %h %h want 0 00000000 000f4240", os, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    int bs, ss;
    logic os, es;
    run_cmd(3'd5, 32'h12345678, 32'd0, 1'b0, 1, "mthi", bs, ss);
    n_checks++;
    if ({hi, 32'(bs)} !== {32'h12345678, 32'd0}) begin
      n_fail++;
      $display("FAIL mthi: hi/busy_cycles got %h %0d want 12345678 0", hi, bs);
    end
    run_cmd(3'd6, 32'hCAFEF00D, 32'd0, 1'b0, 1, "mtlo", bs, ss);
    n_checks++;
    if (lo !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL mtlo: lo got %h want cafef00d", lo);
    end
    drive_cycle(1'b1, 3'd1, 32'd7, 32'd6, 1'b0, os, es);
    for (int i = 1; i <= MULT_N; i++) begin
      drive_cycle(i == 1, (i == 1) ? 3'd6 : 3'd0, 32'hDEADBEEF, 32'd0, 1'b0, os, es);
      n_checks++;
      if ({busy, hi, lo} !== {(m_left > 0), m_hi, m_lo}) begin
        n_fail++;
        $display("FAIL mtlo_in_run cyc%0d: busy/hi/lo got %b %h %h want %b %h %h", i, busy, hi, lo, (m_left > 0), m_hi, m_lo);
      end
    end
    n_checks++;
    if ({hi, lo} !== {32'd0, 32'd42}) begin
      n_fail++;
      $display("FAIL mtlo_ignored: hi/lo got %h %h want 00000000 0000002a", hi, lo);
    end
  endtask

  task automatic test_reset_mid_run();
    int bs, ss;
    logic os, es;
    run_cmd(3'd5, 32'hA5A5A5A5, 32'd0, 1'b0, 1, "pre_reset", bs, ss);
    drive_cycle(1'b1, 3'd1, 32'd5, 32'd5, 1'b1, os, es);
    drive_cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, os, es);
    start = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({hi, lo, busy, stall} !== {64'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_run: hi/lo/busy/stall got %h %h %b %b want 0 0 0 0", hi, lo, busy, stall);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_cmd(3'd1, 32'd9, 32'hFFFFFFFF, 1'b0, MULT_N + 1, "after_reset", bs, ss);
    n_checks++;
    if ({hi, lo, 32'(bs)} !== {32'hFFFFFFFF, 32'hFFFFFFF7, 32'(MULT_N)}) begin
      n_fail++;
      $display("FAIL after_reset_mult: hi/lo/busy_cycles got %h %h %0d want ffffffff fffffff7 %0d", hi, lo, bs, MULT_N);
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    int bs, ss;
    logic [31:0] keep_hi, keep_lo;
    run_cmd(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, DIV_N + 1, "div_neg", bs, ss);
    n_checks++;
    if ({hi, lo, 32'(bs)} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 32'(DIV_N)}) begin
      n_fail++;
      $display("FAIL div_neg: hi/lo/busy_cycles got %h %h %0d want ffffffff fffffffd %0d", hi, lo, bs, DIV_N);
    end
    run_cmd(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, DIV_N + 1, "div_ovf", bs, ss);
    n_checks++;
    if ({hi, lo} !== {32'd0, 32'h80000000}) begin
      n_fail++;
      $display("FAIL div_overflow: hi/lo got %h %h want 00000000 80000000", hi, lo);
    end
    run_cmd(3'd4, 32'd100, 32'd7, 1'b0, DIV_N + 1, "divu", bs, ss);
    keep_hi = hi;
    keep_lo = lo;
    n_checks++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin
      n_fail++;
      $display("FAIL divu: hi/lo got %h %h want 00000002 0000000e", hi, lo);
    end
    run_cmd(3'd3, 32'd55, 32'd0, 1'b0, DIV_N + 1, "div_zero", bs, ss);
    n_checks++;
    if ({hi, lo, 32'(bs)} !== {keep_hi, keep_lo, 32'(DIV_N)}) begin
      n_fail++;
      $display("FAIL div_by_zero: hi/lo/busy_cycles got %h %h %0d want %h %h %0d", hi, lo, bs, keep_hi, keep_lo, DIV_N);
    end
  endtask
`else
  task automatic test_div_disabled();
    int bs, ss;
    logic [31:0] keep_hi, keep_lo;
    keep_hi = hi;
    keep_lo = lo;
    run_cmd(3'd3, 32'd100, 32'd7, 1'b1, 3, "div_off", bs, ss);
    run_cmd(3'd4, 32'd100, 32'd7, 1'b1, 3, "divu_off", bs, ss);
    n_checks++;
    if ({hi, lo, 32'(bs), 32'(ss)} !== {keep_hi, keep_lo, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL div_disabled: hi/lo/busy/stall cycles got %h %h %0d %0d want %h %h 0 0", hi, lo, bs, ss, keep_hi, keep_lo);
    end
  endtask
`endif

  task automatic test_random();
    logic os, es, s, md;
    logic [2:0] o;
    logic [31:0] x, y;
    for (int i = 0; i < 600 + DIV_N; i++) begin
      s  = (i < 600) && ($urandom_range(0, 2) == 0);
      o  = 3'($urandom_range(0, 7));
      x  = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'hFFFFFFFF;
        2: y = 32'($urandom_range(1, 9));
        default: y = $urandom;
      endcase
      md = 1'($urandom_range(0, 1));
      drive_cycle(s, o, x, y, md, os, es);
      n_checks++;
      if ({os, busy, hi, lo} !== {es, (m_left > 0), m_hi, m_lo}) begin
        n_fail++;
        $display("FAIL random cyc%0d: stall/busy/hi/lo got %b %b %h %h want %b %b %h %h",
                 i, os, busy, hi, lo, es, (m_left > 0), m_hi, m_lo);
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL random_drain: pending results got %0d want 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op = 3'd0;
    a = 32'd0;
    b = 32'd0;
    md_use_D = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    test_mult();
    test_stall();
    test_mthi_mtlo();
    test_reset_mid_run();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
